// File: rtl/conv_window_stream_if.sv
// Stream bundle for the sliding-window generator: pixel input side and
// flattened-window output side, each with its own valid/ready handshake.
interface conv_window_stream_if #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int K         = 3,
    parameter int DATA_BITS = 32
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_BITS-1:0]       in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [K*K*DATA_BITS-1:0]   out_data;
    logic [XW-1:0]              out_x;
    logic [YW-1:0]              out_y;
    logic                       out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_x, out_y, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_x, out_y, out_last
    );
endinterface

// File: rtl/conv_window_stream.sv
// Streaming K x K sliding-window generator: raster pixels in, one flattened
// window per stride-aligned position out, using K-1 line buffers.
module conv_window_stream #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int K         = 3,
    parameter int STRIDE    = 1,
    parameter int DATA_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_clr,
    conv_window_stream_if.slave   bus
);
    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H);
    localparam int PW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int WW     = K * K * DATA_BITS;
    localparam int LAST_X = ((IMG_W - K) / STRIDE) * STRIDE;
    localparam int LAST_Y = ((IMG_H - K) / STRIDE) * STRIDE;

    localparam logic [XW-1:0] COL_MAX   = XW'(IMG_W - 1);
    localparam logic [XW-1:0] COL_FIRST = XW'(K - 1);
    localparam logic [XW-1:0] COL_LAST  = XW'(K - 1 + LAST_X);
    localparam logic [YW-1:0] ROW_MAX   = YW'(IMG_H - 1);
    localparam logic [YW-1:0] ROW_FIRST = YW'(K - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(K - 1 + LAST_Y);
    localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);

    logic [XW-1:0]        col_q, col_d;
    logic [YW-1:0]        row_q, row_d;
    logic [PW-1:0]        xph_q, xph_d;
    logic [PW-1:0]        yph_q, yph_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [XW-1:0]        out_x_q, out_x_d;
    logic [YW-1:0]        out_y_q, out_y_d;
    logic [WW-1:0]        out_data_q, out_data_d;

    logic [DATA_BITS-1:0] lb_q   [K-1][IMG_W];
    logic [DATA_BITS-1:0] win_q  [K][K];
    logic [DATA_BITS-1:0] win_d  [K][K];
    logic [DATA_BITS-1:0] col_pix[K];
    logic [WW-1:0]        win_flat;

    logic in_ready;
    logic accept;
    logic emit;

    // Single output register is the only buffering, so input stalls whenever
    // a held window has not been taken.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !soft_clr;

    // Phase counters sit at zero until the first full column/row, so a zero
    // phase past K-1 marks a stride-aligned position without any divider.
    assign emit = accept && (col_q >= COL_FIRST) && (row_q >= ROW_FIRST)
                  && (xph_q == '0) && (yph_q == '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        xph_d = xph_q;
        yph_d = yph_q;
        if (soft_clr) begin
            col_d = '0;
            row_d = '0;
            xph_d = '0;
            yph_d = '0;
        end else if (accept) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                xph_d = '0;
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                    yph_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q < ROW_FIRST) yph_d = '0;
                    else                   yph_d = (yph_q == PH_MAX) ? '0 : yph_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
                if (col_q < COL_FIRST) xph_d = '0;
                else                   xph_d = (xph_q == PH_MAX) ? '0 : xph_q + 1'b1;
            end
        end
    end

    // Incoming column: oldest buffered row on top, the live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K - 1; r++) col_pix[r] = lb_q[K-2-r][col_q];
        col_pix[K-1] = bus.in_data;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][K-1] = col_pix[r];
        end
        win_flat = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win_flat[(r*K+c)*DATA_BITS +: DATA_BITS] = win_d[r][c];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_data_d  = out_data_q;
        if (soft_clr) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
            out_x_d     = col_q - COL_FIRST;
            out_y_d     = row_q - ROW_FIRST;
            out_data_d  = win_flat;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            xph_q       <= '0;
            yph_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            xph_q       <= xph_d;
            yph_q       <= yph_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_data_q  <= out_data_d;
        end
    end

    // NOTE: line buffers and the window shift register carry no reset so they
    // map onto RAM/plain flops; the emit rule never exposes stale contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_d;
            lb_q[0][col_q] <= bus.in_data;
            for (int j = 1; j < K - 1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_conv_window_stream.sv
// Bench for conv_window_stream: two instances (6x5 stride 1, 7x7 stride 2)
// driven through a shared stimulus path and scored against a window-list model.
module tb_conv_window_stream;
    localparam int DB = 16;
    localparam int K  = 3;
    localparam int WW = K * K * DB;

    typedef struct {
        logic [WW-1:0] data;
        logic [31:0]   x;
        logic [31:0]   y;
        logic          last;
        int            cyc;
    } win_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          soft_clr = 1'b0;
    logic          in_valid_v = 1'b0;
    logic [DB-1:0] in_data_v = '0;
    logic          out_ready_v = 1'b1;
    logic          sel = 1'b0;
    logic          mon_en = 1'b0;

    int   total = 0;
    int   bad = 0;
    int   cyc_cnt = 0;
    int   trig_cyc = -1;
    int   n_last = 0;
    int   stim_q[$];
    win_t exp_q[$];
    win_t got_q[$];

    conv_window_stream_if #(.IMG_W(6), .IMG_H(5), .K(K), .DATA_BITS(DB)) a_if ();
    conv_window_stream_if #(.IMG_W(7), .IMG_H(7), .K(K), .DATA_BITS(DB)) b_if ();

    assign a_if.in_valid  = in_valid_v && !sel;
    assign a_if.in_data   = in_data_v;
    assign a_if.out_ready = out_ready_v;
    assign b_if.in_valid  = in_valid_v && sel;
    assign b_if.in_data   = in_data_v;
    assign b_if.out_ready = out_ready_v;

    conv_window_stream #(.IMG_W(6), .IMG_H(5), .K(K), .STRIDE(1), .DATA_BITS(DB)) dut_a (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .bus(a_if));
    conv_window_stream #(.IMG_W(7), .IMG_H(7), .K(K), .STRIDE(2), .DATA_BITS(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .bus(b_if));

    wire          m_valid = sel ? b_if.out_valid : a_if.out_valid;
    wire          m_ready = sel ? b_if.in_ready  : a_if.in_ready;
    wire [WW-1:0] m_data  = sel ? b_if.out_data  : a_if.out_data;
    wire [2:0]    m_x     = sel ? b_if.out_x     : a_if.out_x;
    wire [2:0]    m_y     = sel ? b_if.out_y     : a_if.out_y;
    wire          m_last  = sel ? b_if.out_last  : a_if.out_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: each handshake is compared against the next expected window.
    always @(negedge clk) begin
        if (rst_n && mon_en && m_valid && out_ready_v) begin
            win_t g;
            win_t e;
            g.data = m_data; g.x = {29'b0, m_x}; g.y = {29'b0, m_y};
            g.last = m_last; g.cyc = cyc_cnt;
            got_q.push_back(g);
            if (m_last) n_last++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_window: got x=%0d y=%0d, want no window", m_x, m_y);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.data || m_x !== e.x[2:0] || m_y !== e.y[2:0] || m_last !== e.last) begin
                    bad++;
                    $display("FAIL window: got x=%0d y=%0d last=%b data=%h, want x=%0d y=%0d last=%b data=%h",
                             m_x, m_y, m_last, m_data, e.x, e.y, e.last, e.data);
                end
            end
        end
    end

    // Reference: enumerate every stride-aligned window of a w x h frame.
    task automatic build_expected(input int w, input int h, input int s, input int off);
        for (int y = 0; y + K <= h; y += s) begin
            for (int x = 0; x + K <= w; x += s) begin
                win_t e;
                e.data = '0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        e.data[(r*K+c)*DB +: DB] = DB'(stim_q[off + (y+r)*w + x + c]);
                e.x = x; e.y = y;
                e.last = (y + s + K > h) && (x + s + K > w);
                e.cyc = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic [WW-1:0] pack9(input int v[9]);
        logic [WW-1:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[i*DB +: DB] = DB'(v[i]);
        return p;
    endfunction

    task automatic start_scenario(input logic which);
        sel = which;
        exp_q.delete();
        got_q.delete();
        stim_q.delete();
        n_last = 0;
        trig_cyc = -1;
    endtask

    // Drives stim_q pixel by pixel; optional random gaps, random out_ready and
    // one stall of `stall` cycles once the first window appears.
    task automatic feed(input bit rand_valid, input bit rand_ready, input int stall,
                        input int trig, input bit drain);
        int idx = 0;
        int cyc = 0;
        int stall_left = 0;
        bit pend = (stall > 0);
        bit acc;
        logic [WW-1:0] snap = '0;
        while (idx < stim_q.size() && cyc < 3000) begin
            in_valid_v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data_v  = DB'(stim_q[idx]);
            if (pend && m_valid) begin
                pend = 0;
                stall_left = stall;
                snap = m_data;
            end
            out_ready_v = (stall_left > 0) ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
            @(negedge clk);
            acc = in_valid_v && m_ready;
            if (stall_left > 0) begin
                total++;
                if (m_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== snap) begin
                    bad++;
                    $display("FAIL stall_hold: in_ready=%b out_valid=%b data=%h, want 0 1 %h",
                             m_ready, m_valid, m_data, snap);
                end
                stall_left--;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (idx == trig) trig_cyc = cyc_cnt;
                idx++;
            end
        end
        in_valid_v = 1'b0;
        total++;
        if (idx != stim_q.size()) begin
            bad++;
            $display("FAIL feed_timeout: accepted=%0d, want %0d", idx, stim_q.size());
        end
        if (drain) begin
            out_ready_v = 1'b1;
            cyc = 0;
            while (m_valid === 1'b1 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            total++;
            if (m_valid !== 1'b0) begin
                bad++;
                $display("FAIL drain_timeout: out_valid=%b, want 0", m_valid);
            end
        end
    endtask

    task automatic check_counts(input string name, input int want_n, input int want_last);
        total++;
        if (got_q.size() != want_n || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_count: got %0d windows (%0d unseen), want %0d",
                     name, got_q.size(), exp_q.size(), want_n);
        end
        total++;
        if (n_last != want_last) begin
            bad++;
            $display("FAIL %s_last_count: got %0d, want %0d", name, n_last, want_last);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (a_if.out_valid !== 1'b0 || a_if.out_last !== 1'b0 || a_if.out_x !== '0 ||
            a_if.out_y !== '0 || a_if.out_data !== '0 || a_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_a: valid=%b last=%b x=%0d y=%0d rdy=%b data=%h, want 0 0 0 0 1 0",
                     a_if.out_valid, a_if.out_last, a_if.out_x, a_if.out_y, a_if.in_ready, a_if.out_data);
        end
        total++;
        if (b_if.out_valid !== 1'b0 || b_if.out_last !== 1'b0 || b_if.out_x !== '0 ||
            b_if.out_y !== '0 || b_if.out_data !== '0) begin
            bad++;
            $display("FAIL reset_b: valid=%b last=%b x=%0d y=%0d, want all 0",
                     b_if.out_valid, b_if.out_last, b_if.out_x, b_if.out_y);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int f1[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
        int fl[9] = '{15, 16, 17, 21, 22, 23, 27, 28, 29};
        start_scenario(1'b0);
        for (int i = 0; i < 30; i++) stim_q.push_back(i);
        build_expected(6, 5, 1, 0);
        mon_en = 1'b1;
        feed(0, 0, 0, 14, 1);
        check_counts("basic", 12, 1);
        if (got_q.size() == 12) begin
            total++;
            if (got_q[0].data !== pack9(f1) || got_q[0].x !== 0 || got_q[0].y !== 0) begin
                bad++;
                $display("FAIL basic_first: got %h, want %h", got_q[0].data, pack9(f1));
            end
            total++;
            if (trig_cyc < 0 || got_q[0].cyc != trig_cyc) begin
                bad++;
                $display("FAIL basic_latency: window cycle %0d, want %0d", got_q[0].cyc, trig_cyc);
            end
            total++;
            if (got_q[11].data !== pack9(fl) || got_q[11].x !== 3 || got_q[11].y !== 2 || got_q[11].last !== 1'b1) begin
                bad++;
                $display("FAIL basic_last: got x=%0d y=%0d last=%b, want 3 2 1", got_q[11].x, got_q[11].y, got_q[11].last);
            end
        end
    endtask

    task automatic test_stride();
        int f2[9] = '{2, 3, 4, 9, 10, 11, 16, 17, 18};
        start_scenario(1'b1);
        for (int i = 0; i < 49; i++) stim_q.push_back(i);
        build_expected(7, 7, 2, 0);
        feed(1, 1, 0, -1, 1);
        check_counts("stride", 9, 1);
        if (got_q.size() == 9) begin
            total++;
            if (got_q[1].data !== pack9(f2) || got_q[1].x !== 2 || got_q[1].y !== 0) begin
                bad++;
                $display("FAIL stride_second: got x=%0d data=%h, want 2 %h", got_q[1].x, got_q[1].data, pack9(f2));
            end
            total++;
            if (got_q[8].x !== 4 || got_q[8].y !== 4 || got_q[8].last !== 1'b1) begin
                bad++;
                $display("FAIL stride_last: got x=%0d y=%0d last=%b, want 4 4 1", got_q[8].x, got_q[8].y, got_q[8].last);
            end
        end
    endtask

    task automatic test_backpressure();
        start_scenario(1'b0);
        for (int i = 0; i < 30; i++) stim_q.push_back(i);
        build_expected(6, 5, 1, 0);
        feed(0, 0, 10, -1, 1);
        check_counts("backpressure", 12, 1);
    endtask

    task automatic test_reset_midframe();
        start_scenario(1'b0);
        mon_en = 1'b0;
        for (int i = 0; i < 20; i++) stim_q.push_back(i);
        feed(1, 1, 0, -1, 0);
        rst_n = 1'b0;
        out_ready_v = 1'b1;
        @(negedge clk);
        total++;
        if (a_if.out_valid !== 1'b0 || a_if.out_last !== 1'b0 || a_if.out_x !== '0 ||
            a_if.out_y !== '0 || a_if.out_data !== '0) begin
            bad++;
            $display("FAIL midframe_reset: valid=%b x=%0d y=%0d data=%h, want all 0",
                     a_if.out_valid, a_if.out_x, a_if.out_y, a_if.out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_scenario(1'b0);
        for (int i = 0; i < 30; i++) stim_q.push_back(i);
        build_expected(6, 5, 1, 0);
        mon_en = 1'b1;
        feed(1, 1, 0, -1, 1);
        check_counts("reset_refill", 12, 1);
    endtask

    task automatic test_back_to_back();
        int f3[9] = '{100, 101, 102, 106, 107, 108, 112, 113, 114};
        start_scenario(1'b0);
        for (int i = 0; i < 30; i++) stim_q.push_back(i);
        for (int i = 0; i < 30; i++) stim_q.push_back(100 + i);
        build_expected(6, 5, 1, 0);
        build_expected(6, 5, 1, 30);
        feed(1, 1, 0, -1, 1);
        check_counts("back_to_back", 24, 2);
        if (got_q.size() == 24) begin
            total++;
            if (got_q[12].data !== pack9(f3) || got_q[12].x !== 0 || got_q[12].y !== 0) begin
                bad++;
                $display("FAIL b2b_second_first: got %h, want %h", got_q[12].data, pack9(f3));
            end
        end
    endtask

    task automatic test_soft_clr();
        start_scenario(1'b0);
        mon_en = 1'b0;
        for (int i = 0; i < 16; i++) stim_q.push_back(i);
        feed(0, 0, 0, -1, 0);
        total++;
        if (m_valid !== 1'b1) begin
            bad++;
            $display("FAIL soft_clr_pre: out_valid=%b, want 1", m_valid);
        end
        soft_clr    = 1'b1;
        in_valid_v  = 1'b1;
        in_data_v   = DB'(16);
        out_ready_v = 1'b1;
        @(negedge clk);
        total++;
        if (m_ready !== 1'b1) begin
            bad++;
            $display("FAIL soft_clr_ready: in_ready=%b, want 1", m_ready);
        end
        @(posedge clk); #1;
        soft_clr   = 1'b0;
        in_valid_v = 1'b0;
        total++;
        if (m_valid !== 1'b0 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL soft_clr_flags: out_valid=%b out_last=%b, want 0 0", m_valid, m_last);
        end
        start_scenario(1'b0);
        for (int i = 0; i < 30; i++) stim_q.push_back(200 + i);
        build_expected(6, 5, 1, 0);
        mon_en = 1'b1;
        feed(1, 1, 0, -1, 1);
        check_counts("soft_clr_refill", 12, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_soft_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_window_stream.md
Name: conv_window_stream

Overview:
- Streaming K x K sliding-window generator for the conv layers.
- Takes one pixel per accepted beat in raster order and stores K-1 rows in line buffers instead of a full frame.
- Emits each valid window, with configurable stride, as one flattened bus under valid/ready handshakes on both sides.
- Sits between the pixel source (input DMA or previous layer) and the MAC array. Successor to the full-frame 3x3 buffer: kernel, stride and frame size are parametrised and backpressure is supported.

Parameters:
IMG_W, 28, frame width in pixels (>= K)
IMG_H, 28, frame height in pixels (>= K)
K, 3, kernel edge length (>= 2)
STRIDE, 1, window step in both x and y (>= 1)
DATA_BITS, 32, pixel width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
soft_clr  in  1  synchronous frame restart; clears counters and output valid
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_data  in  DATA_BITS  pixel, raster order
out_valid  out  1  window valid
out_ready  in  1  consumer accepts window
out_data  out  K*K*DATA_BITS  window; element (r,c) at bits [(r*K+c)*DATA_BITS +: DATA_BITS], r=0 top row, c=0 left column
out_x  out  $clog2(IMG_W)  column of the window's top-left pixel
out_y  out  $clog2(IMG_H)  row of the window's top-left pixel
out_last  out  1  high with the final window of the frame

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_last=0, out_x=0, out_y=0, out_data=0. Column and row counters are 0. Line-buffer and shift-register contents are not reset (don't care).
- Ready rule: in_ready = !out_valid || out_ready. There is no internal FIFO beyond the single output register.
- Accept rule: a pixel is accepted when in_valid && in_ready. On accept:
  - the pixel is pushed into the K x K shift window and line buffers;
  - col increments; on col==IMG_W-1, col wraps to 0 and row increments;
  - on row==IMG_H-1 && col==IMG_W-1, both counters wrap to 0, ready for the next frame with no bubble.
- Window emit condition, on the accepted pixel at (row,col):
  - col >= K-1 and row >= K-1;
  - (col-(K-1)) % STRIDE == 0 and (row-(K-1)) % STRIDE == 0.
  - Stride phase is tracked with counters; no divider.
- Emitted window content: out_data holds pixels (row-K+1..row, col-K+1..col). out_x = col-K+1, out_y = row-K+1.
- Latency: out_valid rises on the clock edge that accepts the completing pixel (1-cycle registered output).
- Output hold: out_valid stays high, and out_data/out_x/out_y/out_last stay stable, until out_valid && out_ready.
- Simultaneous events:
  - If the window is consumed and a new completing pixel is accepted in the same cycle, the output register loads the new window and out_valid stays 1.
  - If the window is consumed with no new window, out_valid drops to 0.
- Windows per frame: ((IMG_W-K)/STRIDE+1) * ((IMG_H-K)/STRIDE+1). out_last is high only on the window with the largest out_y and out_x.
- Trailing pixels: pixels beyond the last stride-aligned column/row are accepted and stored but emit nothing.
- soft_clr: same effect as reset on the counters and output flags, synchronous. It takes priority over a same-cycle accept; the pixel is dropped.
- Reset or soft_clr mid-frame: the next accepted pixel is treated as (0,0). No stale window is emitted, because the emit condition needs K-1 fresh rows.
- Line buffers: K-1 rows of IMG_W-K+1..IMG_W entries, inferable as RAM. Read and write occur on the same accept.
- Stall: when in_valid=0, nothing moves.

Test Plan:
1. IMG_W=6, IMG_H=5, K=3, STRIDE=1; pixel=row*6+col, continuous in_valid, out_ready=1 -> first window {0,1,2,6,7,8,12,13,14} at (0,0), 1 cycle after pixel 14 is accepted; 12 windows total; last window {15,16,17,21,22,23,27,28,29} at (3,2) with out_last=1.
2. IMG_W=7, IMG_H=7, K=3, STRIDE=2; pixel=row*7+col -> 9 windows; second window {2,3,4,9,10,11,16,17,18} at (2,0); out_last on the window at (4,4).
3. Config of test 1, out_ready held 0 for 10 cycles after the first window -> out_data stays stable, in_ready=0, no pixel lost; after release the sequence matches test 1 exactly.
4. Config of test 1, rst_n pulsed low after 20 pixels, then a fresh 30-pixel frame -> outputs 0 during reset; exactly 12 windows, identical to test 1.
5. Two back-to-back frames with no gap, second frame pixel=100+index -> 24 windows; first window of the second frame is {100,101,102,106,107,108,112,113,114}; out_last asserted twice.
6. soft_clr in the same cycle as an accepted pixel, mid-frame -> that pixel is dropped, out_valid=0 next cycle, and the next pixel is treated as (0,0).
